// File: rtl/frog_pkg.sv
// Shared frog game types: one-hot move directions {L,R,U,D} and the move
// generator state encoding, reused by the grid and the scoring logic.
package frog_pkg;

  // One-hot move direction, bit order {L,R,U,D}.
  typedef logic [3:0] dir_t;

  localparam dir_t DIR_NONE = 4'b0000;
  localparam dir_t DIR_L    = 4'b1000;
  localparam dir_t DIR_R    = 4'b0100;
  localparam dir_t DIR_U    = 4'b0010;
  localparam dir_t DIR_D    = 4'b0001;

  typedef enum logic [1:0] {
    HOLD = 2'd0,
    IDLE = 2'd1,
    MOVE = 2'd2,
    LOCK = 2'd3
  } move_state_t;

  // True when exactly one direction bit is set.
  function automatic logic is_one_hot(input dir_t v);
    return (v != DIR_NONE) && ((v & (v - 4'd1)) == DIR_NONE);
  endfunction

endpackage

// File: rtl/key_sync.sv
// Parameterised-width two-flop synchroniser for raw asynchronous key levels.
// reset clears both stages so no stale key survives a reset.
module key_sync #(
  parameter int W = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  // Two back-to-back capture stages with synchronous clear.
  always_ff @(posedge clock) begin
    if (reset) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/frog_move_gen.sv
// frog_move_gen: turns the four raw direction keys into clean, registered,
// single-cycle one-hot move pulses L/R/U/D for the playfield grid.
// Keys are synchronised, a single pressed key produces one pulse, moves are
// followed by a lockout window, and reset/crash/win force a full key release.
// Optional feature macro: FROG_MOVE_AUTOREPEAT_EN (auto-repeat while the same
// single key is held). Without it, HOLD only waits for release.
module frog_move_gen #(
  parameter int LOCKOUT_CYCLES = 4,
  parameter int REPEAT_CYCLES  = 8,
  parameter int CNT_W          = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic keyL,
  input  logic keyR,
  input  logic keyU,
  input  logic keyD,
  input  logic crash,
  input  logic win,
  output logic L,
  output logic R,
  output logic U,
  output logic D,
  output logic busy
);

  import frog_pkg::*;

  // Reject configurations the counters cannot represent.
  if (LOCKOUT_CYCLES < 1 || REPEAT_CYCLES < 1 ||
      LOCKOUT_CYCLES > (1 << CNT_W) || REPEAT_CYCLES > (1 << CNT_W)) begin : g_bad_cfg
    $error("frog_move_gen: invalid LOCKOUT_CYCLES/REPEAT_CYCLES/CNT_W");
  end

  localparam logic [CNT_W-1:0] LOCK_LOAD = CNT_W'(LOCKOUT_CYCLES - 1);

  dir_t        k_raw;
  dir_t        k_s;
  logic        clr;

  move_state_t state_q, state_d;
  dir_t        dir_q, dir_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  dir_t        move_q, move_d;
  logic        busy_q, busy_d;

`ifdef FROG_MOVE_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_CYCLES - 1);
  logic [CNT_W-1:0] rcnt_q, rcnt_d;
`endif

  assign k_raw = {keyL, keyR, keyU, keyD};
  assign clr   = reset | crash | win;

  key_sync #(.W(4)) u_key_sync (
    .clock (clock),
    .reset (reset),
    .d_i   (k_raw),
    .q_o   (k_s)
  );

  // Next-state, direction latch, counters and next output values.
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    cnt_d   = cnt_q;
`ifdef FROG_MOVE_AUTOREPEAT_EN
    rcnt_d  = rcnt_q;
`endif
    if (clr) begin
      // Any restart forces a full release before the next move.
      state_d = HOLD;
      dir_d   = DIR_NONE;
      cnt_d   = '0;
`ifdef FROG_MOVE_AUTOREPEAT_EN
      rcnt_d  = '0;
`endif
    end else begin
      case (state_q)
        HOLD: begin
          if (k_s == DIR_NONE) begin
            state_d = IDLE;
`ifdef FROG_MOVE_AUTOREPEAT_EN
            rcnt_d  = '0;
          end else if (k_s == dir_q) begin
            // Same single key still held: count out the repeat period.
            if (rcnt_q == REP_LAST) begin
              state_d = MOVE;
              rcnt_d  = '0;
            end else begin
              rcnt_d  = rcnt_q + CNT_W'(1);
            end
          end else begin
            rcnt_d  = '0;
`else
          end else begin
            state_d = HOLD;
`endif
          end
        end
        IDLE: begin
          if (is_one_hot(k_s)) begin
            dir_d   = k_s;
            state_d = MOVE;
          end else if (k_s != DIR_NONE) begin
            // Chord of keys: no move, wait for full release.
            dir_d   = DIR_NONE;
            state_d = HOLD;
          end else begin
            state_d = IDLE;
          end
        end
        MOVE: begin
          cnt_d   = LOCK_LOAD;
          state_d = LOCK;
        end
        LOCK: begin
          if (cnt_q == '0) begin
            state_d = HOLD;
          end else begin
            cnt_d   = cnt_q - CNT_W'(1);
          end
        end
        default: begin
          state_d = HOLD;
          dir_d   = DIR_NONE;
          cnt_d   = '0;
        end
      endcase
    end
    // Outputs are registered from the next state so the pulse lines up with MOVE.
    move_d = (state_d == MOVE) ? dir_d : DIR_NONE;
    busy_d = (state_d != IDLE);
  end

  // State, counters and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= HOLD;
      dir_q   <= DIR_NONE;
      cnt_q   <= '0;
      move_q  <= DIR_NONE;
      busy_q  <= 1'b1;
`ifdef FROG_MOVE_AUTOREPEAT_EN
      rcnt_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
      move_q  <= move_d;
      busy_q  <= busy_d;
`ifdef FROG_MOVE_AUTOREPEAT_EN
      rcnt_q  <= rcnt_d;
`endif
    end
  end

  assign L    = move_q[3];
  assign R    = move_q[2];
  assign U    = move_q[1];
  assign D    = move_q[0];
  assign busy = busy_q;

endmodule

// File: tb/tb_frog_move_gen.sv
// Directed + random bench for frog_move_gen. Expected pulses (cycle, direction)
// are queued when keys are driven and compared every cycle at the falling edge.
module tb_frog_move_gen;

  localparam int LOCKOUT = 4;
  localparam int MIN_GAP = 1 + LOCKOUT + 2;

  logic clock;
  logic reset;
  logic keyL, keyR, keyU, keyD;
  logic crash, win;
  logic L, R, U, D, busy;

  typedef struct {
    int         cyc;
    logic [3:0] dir;
  } exp_t;

  exp_t       sb_q[$];
  int         cyc;
  int         checks;
  int         errors;
  bit         sb_en;
  int         last_pulse;
  logic [3:0] prev_obs;

  frog_move_gen #(
    .LOCKOUT_CYCLES (LOCKOUT),
    .REPEAT_CYCLES  (8),
    .CNT_W          (4)
  ) dut (
    .clock (clock),
    .reset (reset),
    .keyL  (keyL),
    .keyR  (keyR),
    .keyU  (keyU),
    .keyD  (keyD),
    .crash (crash),
    .win   (win),
    .L     (L),
    .R     (R),
    .U     (U),
    .D     (D),
    .busy  (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Cycle index: during cycle k the last rising edge was edge k.
  always @(posedge clock) cyc <= cyc + 1;

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // A key driven in cycle c is expected to pulse in cycle c+3.
  task automatic push_exp(input int at, input logic [3:0] d);
    exp_t e;
    e.cyc = at;
    e.dir = d;
    sb_q.push_back(e);
  endtask

  task automatic check_busy(input string tag, input logic expv);
    checks++;
    assert (busy === expv) else begin
      errors++;
      $error("FAIL %s cyc=%0d busy observed=%b expected=%b", tag, cyc, busy, expv);
    end
  endtask

  // Per-cycle monitor: scoreboard, one-hot, single-cycle width, pulse spacing.
  always @(negedge clock) begin
    logic [3:0] obs;
    logic [3:0] exp_v;
    obs = {L, R, U, D};
    if (sb_en) begin
      exp_v = 4'b0000;
      if (sb_q.size() != 0 && sb_q[0].cyc == cyc) begin
        exp_v = sb_q[0].dir;
        void'(sb_q.pop_front());
      end
      checks++;
      assert (obs === exp_v) else begin
        errors++;
        $error("FAIL pulse cyc=%0d observed=%b expected=%b", cyc, obs, exp_v);
      end
    end
    checks++;
    assert ($countones(obs) <= 1 && !$isunknown(obs)) else begin
      errors++;
      $error("FAIL onehot cyc=%0d observed=%b expected=at most one bit", cyc, obs);
    end
    checks++;
    assert (!(obs != 4'b0000 && prev_obs != 4'b0000)) else begin
      errors++;
      $error("FAIL width cyc=%0d observed=%b prev=%b expected=single cycle", cyc, obs, prev_obs);
    end
    if (obs != 4'b0000) begin
      if (last_pulse >= 0) begin
        checks++;
        assert (cyc - last_pulse >= MIN_GAP) else begin
          errors++;
          $error("FAIL spacing cyc=%0d observed=%0d expected>=%0d", cyc, cyc - last_pulse, MIN_GAP);
        end
      end
      last_pulse = cyc;
    end
    prev_obs = obs;
  end

  initial begin
    logic [3:0] kv;
    cyc        = 0;
    checks     = 0;
    errors     = 0;
    sb_en      = 1'b1;
    last_pulse = -1;
    prev_obs   = 4'b0000;
    reset = 1'b1;
    {keyL, keyR, keyU, keyD} = 4'b0000;
    crash = 1'b0;
    win   = 1'b0;

    // Reset state.
    tick(1);                                   // cycle 1
    check_busy("reset_busy", 1'b1);

    // Hold keyU: one U pulse at cycle 5, nothing more while held.
    tick(1);                                   // cycle 2
    reset = 1'b0;
    keyU  = 1'b1;
    push_exp(cyc + 3, 4'b0010);
    tick(10);                                  // cycle 12
    check_busy("held_u_busy", 1'b1);
    keyU = 1'b0;
    tick(2);                                   // cycle 14
    check_busy("release_busy_hi", 1'b1);
    tick(1);                                   // cycle 15
    check_busy("release_busy_lo", 1'b0);

    // L pulse, a keyR tap inside LOCK (lost), then a real R pulse.
    tick(5);                                   // cycle 20
    keyL = 1'b1;
    push_exp(cyc + 3, 4'b1000);
    tick(2);
    keyL = 1'b0;
    tick(1);                                   // cycle 23: MOVE
    keyR = 1'b1;
    tick(1);
    keyR = 1'b0;
    tick(8);                                   // cycle 32: back in IDLE
    check_busy("idle_after_lock", 1'b0);
    keyR = 1'b1;
    push_exp(cyc + 3, 4'b0100);
    tick(2);
    keyR = 1'b0;

    // Chord L+D: no pulse, busy until both released.
    tick(10);                                  // cycle 44
    {keyL, keyD} = 2'b11;
    tick(5);
    check_busy("chord_busy1", 1'b1);
    tick(5);
    keyL = 1'b0;
    tick(5);                                   // cycle 59
    check_busy("chord_busy2", 1'b1);
    keyD = 1'b0;
    tick(2);
    check_busy("chord_busy3", 1'b1);
    tick(1);                                   // cycle 62
    check_busy("chord_release", 1'b0);

    // crash on the cycle the FSM would enter MOVE, key held through it.
    tick(4);                                   // cycle 66
    keyD = 1'b1;
    tick(2);
    crash = 1'b1;
    tick(1);
    check_busy("crash_busy", 1'b1);
    tick(2);
    crash = 1'b0;
    tick(10);                                  // cycle 81
    check_busy("crash_held_busy", 1'b1);
    keyD = 1'b0;
    tick(10);                                  // cycle 91
    check_busy("crash_released", 1'b0);
    keyD = 1'b1;
    push_exp(cyc + 3, 4'b0001);
    tick(2);
    keyD = 1'b0;

    // win during LOCK: state restarts in HOLD, then IDLE once keys are clear.
    tick(10);                                  // cycle 103
    keyU = 1'b1;
    push_exp(cyc + 3, 4'b0010);
    tick(2);
    keyU = 1'b0;
    tick(2);
    win = 1'b1;
    tick(1);
    check_busy("win_busy", 1'b1);
    win = 1'b0;
    tick(4);
    check_busy("win_idle", 1'b0);

`ifdef FROG_MOVE_AUTOREPEAT_EN
    // Auto-repeat: R held, pulses every 1 + LOCKOUT + 8 = 13 cycles.
    tick(3);
    keyR = 1'b1;
    push_exp(cyc + 3, 4'b0100);
    push_exp(cyc + 16, 4'b0100);
    push_exp(cyc + 29, 4'b0100);
    tick(38);
    keyR = 1'b0;
    tick(10);
`endif

    // Random key stimulus: only invariant checks.
    tick(10);
    checks++;
    assert (sb_q.size() == 0) else begin
      errors++;
      $error("FAIL directed_drain observed=%0d pending expected=0", sb_q.size());
    end
    sb_en = 1'b0;
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 6))
        0, 1:    kv = 4'b0000;
        2:       kv = 4'b1000;
        3:       kv = 4'b0100;
        4:       kv = 4'b0010;
        5:       kv = 4'b0001;
        default: kv = 4'($urandom_range(0, 15));
      endcase
      {keyL, keyR, keyU, keyD} = kv;
      tick($urandom_range(1, 10));
    end
    {keyL, keyR, keyU, keyD} = 4'b0000;
    tick(20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
